// File: rtl/muldiv_iter_if.sv
// Handshake and operand/result bundle for the iterative multiply/divide unit.
// The controller side is the master, the unit itself is the slave.
interface muldiv_iter_if #(
    parameter int WIDTH = 32
) ();
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result_lo;
    logic [WIDTH-1:0] result_hi;
    logic [3:0]       flags;

    modport master (
        output start, op, a, b,
        input  busy, done, result_lo, result_hi, flags
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result_lo, result_hi, flags
    );
endinterface

// File: rtl/muldiv_iter.sv
// Iterative radix-2 multiply / restoring divide unit.
// One operation per start pulse, WIDTH iteration steps, then a FIX cycle that
// applies sign correction and registers results and NZCV flags.
//
// state | meaning
// IDLE  | waiting for start; results held
// RUN   | one shift-add or restore-divide step per edge
// FIX   | sign correction, results/flags loaded, done pulses next cycle
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         reset,
    muldiv_iter_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [1:0] OP_SMUL = 2'b01;
    localparam logic [1:0] OP_SDIV = 2'b11;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;       // {hi/rem, lo/quo}
    logic [WIDTH-1:0]   opnd_q, opnd_d;     // multiplicand or divisor magnitude
    logic [1:0]         op_q, op_d;
    logic               neg_q, neg_d;       // product / quotient must be negated
    logic               rem_neg_q, rem_neg_d;
    logic               dz_q, dz_d;
    logic               ovf_q, ovf_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [3:0]         flags_q, flags_d;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH:0]   div_sh;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic               sgn_op;
    logic               div_op;

    // Next-state, iteration datapath and result/flag formation
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        op_d      = op_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        dz_d      = dz_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;
        lo_d      = lo_q;
        hi_d      = hi_q;
        flags_d   = flags_q;

        // Shift-add: add multiplicand into the upper half, then shift {carry, acc} right.
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};

        // Restoring divide: shift {rem, quo} left, trial-subtract, keep on no borrow.
        // A borrow implies the shifted-out rem bit was zero, so truncation is safe.
        div_sh   = {acc_q, 1'b0};
        div_diff = div_sh[2*WIDTH:WIDTH] - {1'b0, opnd_q};
        div_next = div_diff[WIDTH] ? div_sh[2*WIDTH-1:0]
                                   : {div_diff[WIDTH-1:0], div_sh[WIDTH-1:1], 1'b1};

        prod    = (op_q == OP_SMUL && neg_q) ? -acc_q : acc_q;
        quo_fix = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

        sgn_op = bus.op[0];
        div_op = bus.op[1];
        a_mag  = (sgn_op && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        b_mag  = (sgn_op && bus.b[WIDTH-1]) ? -bus.b : bus.b;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    op_d      = bus.op;
                    neg_d     = sgn_op & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                    rem_neg_d = sgn_op & bus.a[WIDTH-1];
                    ovf_d     = (bus.op == OP_SDIV) && (bus.a == {1'b1, {(WIDTH-1){1'b0}}})
                                && (bus.b == '1);
                    cnt_d     = '0;
                    if (div_op && bus.b == '0) begin
                        // Divide by zero bypasses RUN; result words are preloaded here.
                        dz_d    = 1'b1;
                        acc_d   = {bus.a, {WIDTH{1'b1}}};
                        state_d = FIX;
                    end else begin
                        dz_d    = 1'b0;
                        acc_d   = div_op ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
                        opnd_d  = div_op ? b_mag : a_mag;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                acc_d = op_q[1] ? div_next : mul_next;
                if (cnt_q == CNT_LAST) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (dz_q) begin
                    lo_d    = acc_q[WIDTH-1:0];
                    hi_d    = acc_q[2*WIDTH-1:WIDTH];
                    flags_d = {acc_q[WIDTH-1], acc_q[WIDTH-1:0] == '0, 1'b0, 1'b1};
                end else if (op_q[1]) begin
                    lo_d    = quo_fix;
                    hi_d    = rem_fix;
                    flags_d = {quo_fix[WIDTH-1], quo_fix == '0, 1'b0, ovf_q};
                end else begin
                    lo_d    = prod[WIDTH-1:0];
                    hi_d    = prod[2*WIDTH-1:WIDTH];
                    flags_d = {prod[2*WIDTH-1], prod == '0,
                               op_q[0] ? (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}})
                                       : (prod[2*WIDTH-1:WIDTH] != '0),
                               1'b0};
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts any operation in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            op_q      <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            dz_q      <= 1'b0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
            lo_q      <= '0;
            hi_q      <= '0;
            flags_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            op_q      <= op_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            dz_q      <= dz_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
            lo_q      <= lo_d;
            hi_q      <= hi_d;
            flags_q   <= flags_d;
        end
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
    assign bus.result_lo = lo_q;
    assign bus.result_hi = hi_q;
    assign bus.flags     = flags_q;
endmodule

// File: tb/tb_muldiv_iter.sv
// Directed bench for muldiv_iter at WIDTH=32: vector table of operations
// applied back-to-back, plus hand sequences for busy-start, reset abort.
module tb_muldiv_iter;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    muldiv_iter_if #(.WIDTH(W)) bus ();
    muldiv_iter #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic [3:0]   fl;
        int           lat;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one op; caller is #1 after a posedge with the unit able to accept.
    // Operands are scrambled right after acceptance to prove they were latched.
    task automatic do_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output int busy_cnt);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.op    = ~op;
        bus.a     = ~a;
        bus.b     = b + 32'd3;
        busy_cnt  = bus.busy ? 1 : 0;
        lat       = 0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                lat = i;
                break;
            end
            if (bus.busy) busy_cnt++;
        end
    endtask

    initial begin
        int lat;
        int bcnt;
        int done_seen;

        vecs[0]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 4'b1010, 33};
        vecs[1]  = '{2'b01, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFEB, 32'hFFFFFFFF, 4'b1000, 33};
        vecs[2]  = '{2'b01, 32'h00000000, 32'h12345678, 32'h00000000, 32'h00000000, 4'b0100, 33};
        vecs[3]  = '{2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF, 4'b1000, 33};
        vecs[4]  = '{2'b10, 32'd100,      32'd7,        32'd14,       32'd2,        4'b0000, 33};
        vecs[5]  = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 4'b1001, 33};
        vecs[6]  = '{2'b10, 32'h00001234, 32'h00000000, 32'hFFFFFFFF, 32'h00001234, 4'b1001, 1};
        vecs[7]  = '{2'b00, 32'd3,        32'd5,        32'd15,       32'd0,        4'b0000, 33};
        vecs[8]  = '{2'b01, 32'h80000000, 32'h80000000, 32'h00000000, 32'h40000000, 4'b0010, 33};
        vecs[9]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0000, 33};
        vecs[10] = '{2'b11, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001, 4'b1000, 33};
        vecs[11] = '{2'b11, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFB, 4'b1001, 1};
        vecs[12] = '{2'b00, 32'h00010000, 32'h00010000, 32'h00000000, 32'h00000001, 4'b0010, 33};
        vecs[13] = '{2'b10, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 4'b1000, 33};

        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = '0;
        bus.b     = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy",  {63'd0, bus.busy}, 64'd0);
        chk("reset_done",  {63'd0, bus.done}, 64'd0);
        chk("reset_lo",    {32'd0, bus.result_lo}, 64'd0);
        chk("reset_hi",    {32'd0, bus.result_hi}, 64'd0);
        chk("reset_flags", {60'd0, bus.flags}, 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Table: each op issued in the done cycle of the previous one.
        foreach (vecs[k]) begin
            do_op(vecs[k].op, vecs[k].a, vecs[k].b, lat, bcnt);
            chk($sformatf("v%0d_latency", k), 64'(lat), 64'(vecs[k].lat));
            chk($sformatf("v%0d_busy", k), 64'(bcnt), 64'(vecs[k].lat));
            chk($sformatf("v%0d_lo", k), {32'd0, bus.result_lo}, {32'd0, vecs[k].lo});
            chk($sformatf("v%0d_hi", k), {32'd0, bus.result_hi}, {32'd0, vecs[k].hi});
            chk($sformatf("v%0d_flags", k), {60'd0, bus.flags}, {60'd0, vecs[k].fl});
        end
        @(posedge clk); #1;
        chk("done_one_cycle", {63'd0, bus.done}, 64'd0);
        chk("result_hold", {32'd0, bus.result_lo}, 64'h00000000FFFFFFFF);

        // Start while busy: a divide-by-zero pulse at E0+5 must be ignored.
        bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'd3; bus.b = 32'd5;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        bus.start = 1'b1; bus.op = 2'b10; bus.a = 32'hFFFF; bus.b = 32'd0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 0;
        for (int i = 6; i <= 100; i++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                lat = i;
                break;
            end
        end
        chk("busy_start_latency", 64'(lat), 64'd33);
        chk("busy_start_lo", {32'd0, bus.result_lo}, 64'd15);
        chk("busy_start_hi", {32'd0, bus.result_hi}, 64'd0);
        chk("busy_start_flags", {60'd0, bus.flags}, 64'd0);

        // Start in the done cycle is accepted with no bubble.
        do_op(2'b10, 32'd100, 32'd7, lat, bcnt);
        chk("b2b_latency", 64'(lat), 64'd33);
        chk("b2b_lo", {32'd0, bus.result_lo}, 64'd14);
        chk("b2b_hi", {32'd0, bus.result_hi}, 64'd2);

        // Reset at E0+10 aborts a UMUL with no done pulse.
        bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'hFFFFFFFF; bus.b = 32'hFFFFFFFF;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("abort_busy",  {63'd0, bus.busy}, 64'd0);
        chk("abort_done",  {63'd0, bus.done}, 64'd0);
        chk("abort_lo",    {32'd0, bus.result_lo}, 64'd0);
        chk("abort_hi",    {32'd0, bus.result_hi}, 64'd0);
        chk("abort_flags", {60'd0, bus.flags}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) done_seen++;
        end
        chk("abort_no_done", 64'(done_seen), 64'd0);
        do_op(2'b00, 32'd3, 32'd5, lat, bcnt);
        chk("post_reset_latency", 64'(lat), 64'd33);
        chk("post_reset_lo", {32'd0, bus.result_lo}, 64'd15);
        chk("post_reset_hi", {32'd0, bus.result_hi}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
